// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch slice (package risc_pkg).
package risc_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_t;

  // One buffered fetch: the instruction word and the address it came from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  // Clear the byte-offset bits so the result is a word address.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction memory port, redirect input and decode port.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN adds misalign_err.
interface fetch_unit_if;
  import risc_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [ILEN-1:0] imem_rdata;
  logic            pc_src;
  logic [XLEN-1:0] pc_target;
  logic [ILEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            instr_valid;
  logic            instr_ready;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic            misalign_err;
`endif

  // Fetch unit side.
  modport master (
`ifdef FETCH_MISALIGN_TRAP_EN
    output misalign_err,
`endif
    output imem_req, imem_addr, instr, instr_pc, instr_valid,
    input  imem_ack, imem_rdata, pc_src, pc_target, instr_ready
  );

  // Memory / branch / decode side.
  modport slave (
`ifdef FETCH_MISALIGN_TRAP_EN
    input  misalign_err,
`endif
    input  imem_req, imem_addr, instr, instr_pc, instr_valid,
    output imem_ack, imem_rdata, pc_src, pc_target, instr_ready
  );

endinterface

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: small instruction buffer with push, pop and flush; DEPTH must be 2 or 4.
module fetch_fifo #(
  parameter  int DEPTH = 2,
  parameter  int W     = 64,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop frees the slot in the same edge, so push on a full buffer is allowed then.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush discards everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; an empty buffer's contents are never shown.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetch FSM and PC, feeding a fetch_fifo toward decode.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (reject misaligned redirects, pulse misalign_err).
module fetch_unit
  import risc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_M1 = CNT_W'(FIFO_DEPTH - 1);

  fetch_state_t    state;
  fetch_state_t    state_nxt;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc;
  logic            redirect;
  logic            imem_req_c;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  fetch_entry_t    head;
  fetch_entry_t    entry_in;
  logic            slot_free_idle;
  logic            slot_free_ack;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misaligned;
  logic misalign_err_q;

  assign misaligned = (bus.pc_target[1:0] != 2'b00);
  assign redirect   = bus.pc_src && !misaligned;

  // One-cycle error pulse for a rejected misaligned redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_err_q <= 1'b0;
    else     misalign_err_q <= bus.pc_src && misaligned;
  end

  assign bus.misalign_err = misalign_err_q;
`else
  assign redirect = bus.pc_src;
`endif

  // Decode handshake and the ack that lands a fetch in the buffer.
  assign pop  = !fifo_empty && bus.instr_ready;
  assign push = (state == ST_WAIT) && bus.imem_ack && !redirect;

  // In WAIT the in-flight fetch already owns a slot; after its push another
  // fetch fits if decode pops this edge or at least two slots were free.
  assign slot_free_idle = !fifo_full;
  assign slot_free_ack  = pop || (fifo_count < DEPTH_M1);

  assign entry_in = '{pc: req_pc, instr: bus.imem_rdata};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(fetch_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   (entry_in),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; a redirect overrides push/pop and discards a same-cycle ack.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (redirect || slot_free_idle) state_nxt = ST_REQ;
      ST_REQ:  state_nxt = redirect ? ST_DROP : ST_WAIT;
      ST_WAIT: begin
        if (redirect)          state_nxt = bus.imem_ack ? ST_REQ : ST_DROP;
        else if (bus.imem_ack) state_nxt = slot_free_ack ? ST_REQ : ST_IDLE;
      end
      ST_DROP: if (bus.imem_ack) state_nxt = ST_REQ;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: a request is presented only in REQ.
  always_comb begin
    imem_req_c = 1'b0;
    if (state == ST_REQ) imem_req_c = 1'b1;
  end

  // Fetch PC and the address of the outstanding request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
    end else begin
      if (redirect)              fetch_pc <= word_align(bus.pc_target);
      else if (state == ST_REQ)  fetch_pc <= fetch_pc + XLEN'(4);
      if (state == ST_REQ)       req_pc   <= fetch_pc;
    end
  end

  assign bus.imem_req    = imem_req_c;
  assign bus.imem_addr   = fetch_pc;
  assign bus.instr_valid = !fifo_empty;
  assign bus.instr       = fifo_empty ? '0 : head.instr;
  assign bus.instr_pc    = fifo_empty ? '0 : head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit (FIFO_DEPTH=2); honours FETCH_MISALIGN_TRAP_EN.
module tb_fetch_unit;
  import risc_pkg::*;

  logic            clk;
  logic            rst;
  logic            ack_auto, ack_man, mem_auto;
  logic [ILEN-1:0] rdata_auto, rdata_man;
  logic            pc_src, ready;
  logic [XLEN-1:0] pc_target;

  int checks;
  int failures;
  int req_cnt;
  logic [XLEN-1:0] got_pc  [8];
  logic [ILEN-1:0] got_ins [8];
  int got_n;

  fetch_unit_if bus();

  assign bus.imem_ack    = ack_auto | ack_man;
  assign bus.imem_rdata  = ack_man ? rdata_man : rdata_auto;
  assign bus.pc_src      = pc_src;
  assign bus.pc_target   = pc_target;
  assign bus.instr_ready = ready;

  fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Request monitor.
  initial begin
    req_cnt = 0;
    forever begin
      @(negedge clk);
      if (bus.imem_req === 1'b1) req_cnt++;
    end
  end

  // Auto memory: ack exactly one cycle after each request, data = ~address.
  initial begin
    logic [XLEN-1:0] a;
    ack_auto = 1'b0;
    rdata_auto = '0;
    forever begin
      @(negedge clk);
      if (mem_auto && bus.imem_req === 1'b1 && !rst) begin
        a = bus.imem_addr;
        @(posedge clk); #1;
        ack_auto = 1'b1;
        rdata_auto = ~a;
        @(posedge clk); #1;
        ack_auto = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    mem_auto = 1'b0; ack_man = 1'b0; pc_src = 1'b0; ready = 1'b0; pc_target = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_req(output logic [XLEN-1:0] a);
    a = 'x;
    for (int k = 0; k < 20; k++) begin
      if (bus.imem_req === 1'b1) begin
        a = bus.imem_addr;
        return;
      end
      tick();
    end
    checks++; failures++;
    $display("FAIL wait_req timeout: imem_req got 0 required 1");
  endtask

  // Wait for a request, then acknowledge it one cycle later with ~address.
  task automatic man_ack(output logic [XLEN-1:0] a);
    wait_req(a);
    tick();
    ack_man = 1'b1;
    rdata_man = ~a;
    tick();
    ack_man = 1'b0;
  endtask

  task automatic collect(input int n, input int budget);
    got_n = 0;
    for (int k = 0; k < budget && got_n < n; k++) begin
      if (bus.instr_valid === 1'b1) begin
        got_pc[got_n]  = bus.instr_pc;
        got_ins[got_n] = bus.instr;
        got_n++;
      end
      if (got_n < n) tick();
    end
  endtask

  task automatic test_reset();
    ready = 1'b0; pc_src = 1'b0; pc_target = '0; ack_man = 1'b0; mem_auto = 1'b0; rdata_man = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b req=0", bus.imem_req); end
    checks++; if (bus.imem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h req=0", bus.imem_addr); end
    checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b req=0", bus.instr_valid); end
    checks++; if (bus.instr !== 32'h0) begin failures++; $display("FAIL rst_instr got=%h req=0", bus.instr); end
    checks++; if (bus.instr_pc !== 32'h0) begin failures++; $display("FAIL rst_instr_pc got=%h req=0", bus.instr_pc); end
  endtask

  task automatic test_sequential();
    int n;
    logic [XLEN-1:0] exp_pc [3];
    exp_pc = '{32'h0, 32'h4, 32'h8};
    do_reset();
    mem_auto = 1'b1;
    ready = 1'b1;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      n++;
      if (bus.instr_valid === 1'b1) break;
    end
    checks++; if (n != 3) begin failures++; $display("FAIL seq_latency got=%0d req=3", n); end
    collect(3, 30);
    checks++; if (got_n != 3) begin failures++; $display("FAIL seq_count got=%0d req=3", got_n); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (got_pc[i] !== exp_pc[i]) begin failures++; $display("FAIL seq_pc%0d got=%h req=%h", i, got_pc[i], exp_pc[i]); end
      checks++; if (got_ins[i] !== ~exp_pc[i]) begin failures++; $display("FAIL seq_instr%0d got=%h req=%h", i, got_ins[i], ~exp_pc[i]); end
    end
  endtask

  task automatic test_backpressure();
    int base;
    logic [XLEN-1:0] exp_pc [4];
    exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC};
    do_reset();
    mem_auto = 1'b1;
    ready = 1'b0;
    base = req_cnt;
    repeat (10) tick();
    checks++; if (bus.instr_valid !== 1'b1) begin failures++; $display("FAIL bp_valid got=%b req=1", bus.instr_valid); end
    checks++; if (bus.instr_pc !== 32'h0) begin failures++; $display("FAIL bp_head_pc got=%h req=0", bus.instr_pc); end
    checks++; if (req_cnt - base != 2) begin failures++; $display("FAIL bp_reqs got=%0d req=2", req_cnt - base); end
    checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL bp_req_full got=%b req=0", bus.imem_req); end
    repeat (5) tick();
    checks++; if (req_cnt - base != 2) begin failures++; $display("FAIL bp_reqs_hold got=%0d req=2", req_cnt - base); end
    ready = 1'b1;
    collect(4, 40);
    checks++; if (got_n != 4) begin failures++; $display("FAIL bp_count got=%0d req=4", got_n); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (got_pc[i] !== exp_pc[i]) begin failures++; $display("FAIL bp_pc%0d got=%h req=%h", i, got_pc[i], exp_pc[i]); end
      checks++; if (got_ins[i] !== ~exp_pc[i]) begin failures++; $display("FAIL bp_instr%0d got=%h req=%h", i, got_ins[i], ~exp_pc[i]); end
    end
  endtask

  task automatic test_redirect_drop();
    logic [XLEN-1:0] a;
    do_reset();
    ready = 1'b1;
    man_ack(a);
    man_ack(a);
    wait_req(a);
    checks++; if (a !== 32'h8) begin failures++; $display("FAIL rd_third_addr got=%h req=8", a); end
    tick();
    pc_src = 1'b1; pc_target = 32'h100;
    tick();
    pc_src = 1'b0;
    checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL rd_drop_req got=%b req=0", bus.imem_req); end
    checks++; if (bus.imem_addr !== 32'h100) begin failures++; $display("FAIL rd_drop_addr got=%h req=100", bus.imem_addr); end
    ack_man = 1'b1; rdata_man = ~32'h8;
    tick();
    ack_man = 1'b0;
    checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL rd_dropped_valid got=%b req=0", bus.instr_valid); end
    checks++; if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL rd_restart_req got=%b req=1", bus.imem_req); end
    checks++; if (bus.imem_addr !== 32'h100) begin failures++; $display("FAIL rd_restart_addr got=%h req=100", bus.imem_addr); end
    mem_auto = 1'b1;
    collect(2, 30);
    checks++; if (got_n != 2) begin failures++; $display("FAIL rd_count got=%0d req=2", got_n); end
    checks++; if (got_pc[0] !== 32'h100) begin failures++; $display("FAIL rd_pc0 got=%h req=100", got_pc[0]); end
    checks++; if (got_ins[0] !== ~32'h100) begin failures++; $display("FAIL rd_instr0 got=%h req=%h", got_ins[0], ~32'h100); end
    checks++; if (got_pc[1] !== 32'h104) begin failures++; $display("FAIL rd_pc1 got=%h req=104", got_pc[1]); end
  endtask

  task automatic test_flush_push_pop();
    logic [XLEN-1:0] a;
    do_reset();
    ready = 1'b0;
    man_ack(a);
    wait_req(a);
    checks++; if (a !== 32'h4) begin failures++; $display("FAIL fl_second_addr got=%h req=4", a); end
    tick();
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0) begin
      failures++; $display("FAIL fl_pre_head got=%b/%h req=1/0", bus.instr_valid, bus.instr_pc);
    end
    ready = 1'b1; ack_man = 1'b1; rdata_man = ~32'h4; pc_src = 1'b1; pc_target = 32'h200;
    tick();
    ready = 1'b0; ack_man = 1'b0; pc_src = 1'b0;
    checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL fl_valid got=%b req=0", bus.instr_valid); end
    checks++; if (bus.imem_addr !== 32'h200) begin failures++; $display("FAIL fl_addr got=%h req=200", bus.imem_addr); end
    checks++; if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL fl_req got=%b req=1", bus.imem_req); end
  endtask

  task automatic test_reset_mid_wait();
    logic [XLEN-1:0] a;
    do_reset();
    ready = 1'b0;
    man_ack(a);
    wait_req(a);
    tick();
    #3;
    rst = 1'b1;
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL mw_req got=%b req=0", bus.imem_req); end
    checks++; if (bus.imem_addr !== 32'h0) begin failures++; $display("FAIL mw_addr got=%h req=0", bus.imem_addr); end
    checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL mw_valid got=%b req=0", bus.instr_valid); end
    checks++; if (bus.instr !== 32'h0) begin failures++; $display("FAIL mw_instr got=%h req=0", bus.instr); end
    checks++; if (bus.instr_pc !== 32'h0) begin failures++; $display("FAIL mw_instr_pc got=%h req=0", bus.instr_pc); end
    @(negedge clk);
    rst = 1'b0;
    ack_man = 1'b1; rdata_man = 32'hDEAD_BEEF;
    tick();
    ack_man = 1'b0;
    checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL mw_late_ack got=%b req=0", bus.instr_valid); end
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      failures++; $display("FAIL mw_restart got=%b/%h req=1/0", bus.imem_req, bus.imem_addr);
    end
    mem_auto = 1'b1;
    ready = 1'b1;
    collect(1, 20);
    checks++; if (got_n != 1 || got_pc[0] !== 32'h0 || got_ins[0] !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL mw_first got=%0d/%h/%h req=1/0/ffffffff", got_n, got_pc[0], got_ins[0]);
    end
  endtask

  task automatic test_misalign();
    logic [XLEN-1:0] a;
    do_reset();
    ready = 1'b0;
    wait_req(a);
    tick();
    pc_src = 1'b1; pc_target = 32'h102;
    tick();
    pc_src = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    checks++; if (bus.misalign_err !== 1'b1) begin failures++; $display("FAIL ma_err got=%b req=1", bus.misalign_err); end
    checks++; if (bus.imem_addr !== 32'h4) begin failures++; $display("FAIL ma_addr got=%h req=4", bus.imem_addr); end
    ack_man = 1'b1; rdata_man = ~32'h0;
    tick();
    ack_man = 1'b0;
    checks++; if (bus.misalign_err !== 1'b0) begin failures++; $display("FAIL ma_err_pulse got=%b req=0", bus.misalign_err); end
    checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0) begin
      failures++; $display("FAIL ma_kept got=%b/%h req=1/0", bus.instr_valid, bus.instr_pc);
    end
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) begin
      failures++; $display("FAIL ma_seq got=%b/%h req=1/4", bus.imem_req, bus.imem_addr);
    end
`else
    checks++; if (bus.imem_addr !== 32'h100) begin failures++; $display("FAIL ma_addr got=%h req=100", bus.imem_addr); end
    checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL ma_drop_req got=%b req=0", bus.imem_req); end
    ack_man = 1'b1; rdata_man = ~32'h0;
    tick();
    ack_man = 1'b0;
    checks++; if (bus.instr_valid !== 1'b0) begin failures++; $display("FAIL ma_dropped got=%b req=0", bus.instr_valid); end
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin
      failures++; $display("FAIL ma_resume got=%b/%h req=1/100", bus.imem_req, bus.imem_addr);
    end
`endif
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    mem_auto = 1'b0; ack_man = 1'b0; rdata_man = '0;
    pc_src = 1'b0; pc_target = '0; ready = 1'b0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_drop();
    test_flush_push_pop();
    test_reset_mid_wait();
    test_misalign();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
